// File: rtl/oam_pkg.sv
// oam_pkg: OAM entry field layout, evaluator FSM states and the vertical hit test
package oam_pkg;
   localparam int ENABLE_BIT     = 31;
   localparam int X_FLIP_BIT     = 30;
   localparam int POS_X_MSB      = 25;
   localparam int POS_X_LSB      = 16;
   localparam int POS_Y_MSB      = 15;
   localparam int POS_Y_LSB      = 6;
   localparam int SPRITE_ROW_MSB = 5;
   localparam int SPRITE_ROW_LSB = 3;
   localparam int SPRITE_COL_MSB = 2;
   localparam int SPRITE_COL_LSB = 0;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} eval_state_t;
   // 11-bit compare so pos_y + height never wraps back onto low lines
   function automatic logic y_in_range(input logic [9:0] pos_y, input logic [9:0] y, input logic [10:0] height);
      logic [10:0] lo;
      lo = {1'b0, pos_y};
      return ({1'b0, y} >= lo) && ({1'b0, y} < lo + height);
   endfunction
endpackage

// File: rtl/oam_line_evaluator.sv
// oam_line_evaluator: per-line OAM scan that copies up to CACHE_DEPTH hitting sprites into the line cache
// Ports: clk/rst (async active-high); eval_start/eval_y start a scan for one line;
// oam_addr/oam_rd_en/oam_data form the synchronous OAM read port; cache_we/cache_waddr/cache_wdata
// write the line cache; cache_count/overflow report the result; busy during a scan, done pulses at the end.
module oam_line_evaluator
   import oam_pkg::*;
#(
   parameter int OAM_WIDTH   = 32,
   parameter int OAM_DEPTH   = 8,
   parameter int TILE_HEIGHT = 32,
   parameter int CACHE_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           eval_start,
   input  logic [9:0]                     eval_y,
   output logic [$clog2(OAM_DEPTH)-1:0]   oam_addr,
   output logic                           oam_rd_en,
   input  logic [OAM_WIDTH-1:0]           oam_data,
   output logic                           cache_we,
   output logic [$clog2(CACHE_DEPTH)-1:0] cache_waddr,
   output logic [OAM_WIDTH-1:0]           cache_wdata,
   output logic [$clog2(CACHE_DEPTH):0]   cache_count,
   output logic                           overflow,
   output logic                           busy,
   output logic                           done
);
   localparam int AW = $clog2(OAM_DEPTH);
   localparam int CW = $clog2(CACHE_DEPTH);
   eval_state_t   state;
   logic [9:0]    ey;
   logic          rd_vld;
   logic          drain_last;
   logic [CW:0]   slot;
   logic          hit;
   logic          full;
   // rd_vld marks the cycle in which oam_data answers an issued read
   always_comb hit = rd_vld && oam_data[ENABLE_BIT] && y_in_range(oam_data[POS_Y_MSB:POS_Y_LSB], ey, 11'(TILE_HEIGHT));
   always_comb full = slot == (CW+1)'(CACHE_DEPTH);
   // slot runs one cycle ahead of cache_count so back-to-back hits get distinct slots
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         ey          <= '0;
         rd_vld      <= 1'b0;
         drain_last  <= 1'b0;
         slot        <= '0;
         oam_addr    <= '0;
         oam_rd_en   <= 1'b0;
         cache_we    <= 1'b0;
         cache_waddr <= '0;
         cache_wdata <= '0;
         cache_count <= '0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done     <= 1'b0;
         cache_we <= 1'b0;
         rd_vld   <= oam_rd_en;
         if (cache_we) cache_count <= cache_count + 1'b1;
         if (hit && !full) begin
            cache_we    <= 1'b1;
            cache_waddr <= slot[CW-1:0];
            cache_wdata <= oam_data;
            slot        <= slot + 1'b1;
         end
         if (hit && full) overflow <= 1'b1;
         case (state)
            IDLE: if (eval_start) begin
               state       <= SCAN;
               ey          <= eval_y;
               slot        <= '0;
               cache_count <= '0;
               overflow    <= 1'b0;
               oam_addr    <= '0;
               oam_rd_en   <= 1'b1;
               busy        <= 1'b1;
            end
            SCAN: if (oam_addr == AW'(OAM_DEPTH-1)) begin
               state      <= DRAIN;
               oam_rd_en  <= 1'b0;
               drain_last <= 1'b0;
            end else oam_addr <= oam_addr + 1'b1;
            DRAIN: begin
               drain_last <= 1'b1;
               if (drain_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_oam_line_evaluator.sv
// tb_oam_line_evaluator: directed and random scans checked against a list-based model of sprite selection
module tb_oam_line_evaluator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        eval_start = 1'b0;
   logic [9:0]  eval_y = '0;
   logic [2:0]  oam_addr;
   logic        oam_rd_en;
   logic [31:0] oam_data = '0;
   logic        cache_we;
   logic [1:0]  cache_waddr;
   logic [31:0] cache_wdata;
   logic [2:0]  cache_count;
   logic        overflow;
   logic        busy;
   logic        done;
   int tests = 0;
   int fails = 0;
   logic [31:0] mem [8];
   typedef struct {int cyc; int slot; logic [31:0] data;} wr_t;
   wr_t wq[$];
   int  exp_q[$];
   bit  exp_ovf;

   oam_line_evaluator dut (
      .clk(clk), .rst(rst), .eval_start(eval_start), .eval_y(eval_y),
      .oam_addr(oam_addr), .oam_rd_en(oam_rd_en), .oam_data(oam_data),
      .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
      .cache_count(cache_count), .overflow(overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (oam_rd_en) oam_data <= mem[oam_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: the sprites on a line are the enabled entries whose 32-line span covers it, in OAM order
   task automatic model(input int ey);
      exp_q = {};
      for (int i = 0; i < 8; i++) begin
         int p;
         p = int'(mem[i][15:6]);
         if (mem[i][31] && ey >= p && ey < p + 32) exp_q.push_back(i);
      end
      exp_ovf = exp_q.size() > 4;
   endtask

   function automatic logic [31:0] entry(input bit en, input int pos);
      logic [31:0] w;
      w = $urandom;
      w[31] = en;
      w[15:6] = pos[9:0];
      return w;
   endfunction

   // Called at the negedge of cycle 0 after eval_start was raised; returns at the negedge of cycle 11
   task automatic scan_body(input int ey, input bit pulse3, input bit pulse11, input int ey2);
      int n_exp;
      wq = {};
      model(ey);
      n_exp = exp_q.size() > 4 ? 4 : exp_q.size();
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         eval_start = 1'b0;
         if (cache_we) wq.push_back('{k, int'(cache_waddr), cache_wdata});
         chk($sformatf("busy@%0d", k), 64'(busy), 64'(k <= 10));
         chk($sformatf("rd_en@%0d", k), 64'(oam_rd_en), 64'(k <= 8));
         chk($sformatf("done@%0d", k), 64'(done), 64'(k == 11));
         if (k <= 8) chk($sformatf("addr@%0d", k), 64'(oam_addr), 64'(k - 1));
         if (k == 1) begin
            chk("count_clr", 64'(cache_count), 64'd0);
            chk("ovf_clr", 64'(overflow), 64'd0);
         end
         if (k == 11) begin
            chk("count", 64'(cache_count), 64'(n_exp));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
         end
         if (k == 3 && pulse3) begin
            eval_start = 1'b1;
            eval_y = 10'(ey ^ 10'h2AA);
         end
         if (k == 11 && pulse11) begin
            eval_start = 1'b1;
            eval_y = 10'(ey2);
         end
      end
      chk("nwrites", 64'(wq.size()), 64'(n_exp));
      for (int i = 0; i < n_exp && i < wq.size(); i++) begin
         chk($sformatf("wslot%0d", i), 64'(wq[i].slot), 64'(i));
         chk($sformatf("wdata%0d", i), 64'(wq[i].data), 64'(mem[exp_q[i]]));
         chk($sformatf("wcyc%0d", i), 64'(wq[i].cyc), 64'(exp_q[i] + 3));
      end
   endtask

   task automatic start(input int ey);
      @(negedge clk);
      eval_start = 1'b1;
      eval_y = 10'(ey);
   endtask

   task automatic scan(input int ey);
      start(ey);
      scan_body(ey, 1'b0, 1'b0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"}, 64'(oam_addr), 64'd0);
      chk({tag, "_rd_en"}, 64'(oam_rd_en), 64'd0);
      chk({tag, "_we"}, 64'(cache_we), 64'd0);
      chk({tag, "_waddr"}, 64'(cache_waddr), 64'd0);
      chk({tag, "_wdata"}, 64'(cache_wdata), 64'd0);
      chk({tag, "_count"}, 64'(cache_count), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = entry(1'b0, 100);
      scan(100);
      for (int i = 0; i < 8; i++) mem[i] = entry(1'b0, 90);
      mem[2] = entry(1'b1, 90);
      mem[5] = entry(1'b1, 90);
      scan(100);
      for (int i = 0; i < 8; i++) mem[i] = entry(1'b1, 100);
      scan(131);
      scan(132);
      for (int i = 0; i < 8; i++) mem[i] = entry(1'b0, 500);
      mem[0] = entry(1'b1, 1023);
      scan(0);
      scan(1023);
      mem[0] = entry(1'b1, 0);
      scan(0);
      for (int i = 0; i < 8; i++) mem[i] = entry(1'b1, 100);
      start(131);
      scan_body(131, 1'b1, 1'b1, 200);
      scan_body(200, 1'b0, 1'b0, 0);
      for (int r = 0; r < 24; r++) begin
         int ey;
         ey = int'($urandom_range(0, 1023));
         for (int i = 0; i < 8; i++)
            mem[i] = entry(1'($urandom_range(0, 3) != 0), (ey + 1024 - int'($urandom_range(0, 40))) % 1024);
         scan(ey);
      end
      mem[2] = entry(1'b1, 90);
      start(100);
      repeat (6) @(negedge clk) eval_start = 1'b0;
      rst = 1'b1;
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("nodone%0d", k), 64'(done | busy | cache_we), 64'd0);
      end
      for (int i = 0; i < 8; i++) mem[i] = entry(1'b0, 90);
      mem[2] = entry(1'b1, 90);
      mem[5] = entry(1'b1, 90);
      scan(100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
